fpll_rcnf_engine: RTL and testbench



---
 rtl/fpll_rcnf_pkg.sv | 29 ++
 rtl/fpll_rcnf_timer.sv | 26 ++
 rtl/fpll_rcnf_engine.sv | 189 ++++++++++++++++++
 tb/tb_fpll_rcnf_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpll_rcnf_pkg.sv
// Shared types and constants for the fPLL reconfiguration engine.
//   state_t : engine FSM states
//   op_t    : which command is in flight, steering RD/WR exits
//   fixed Avalon-MM addresses/data for bus arbitration and the status poll
package fpll_rcnf_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_POLL_RD, S_CAL_RISE, S_CAL_FALL
  } state_t;

  typedef enum logic [1:0] {
    OP_RCNF, OP_REQ, OP_REL, OP_SCAL
  } op_t;

  localparam logic [9:0]  ADDR_CBUS_ARB     = 10'h000;
  localparam logic [9:0]  ADDR_CAPAB_STATUS = 10'h280;
  localparam logic [31:0] CBUS_REQ          = 32'h2;
  localparam logic [31:0] CBUS_REL          = 32'h1;
  localparam int          CBUS_BUSY_BIT     = 2;
  localparam int          TMR_W             = 21;

  // Masked bits come from the new data, the rest keep the register contents.
  function automatic logic [31:0] rmw_merge(input logic [31:0] rd,
                                            input logic [31:0] data,
                                            input logic [31:0] mask);
    return (rd & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/fpll_rcnf_timer.sv
// Loadable saturating down-counter shared by the poll and calibration waits.
//   i_load/i_load_val : (re)arm on state entry (wins over i_dec)
//   i_dec             : count one step; holds at zero
//   o_expired         : counter is at zero
module fpll_rcnf_timer #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_cnt <= '0;
    else if (i_load)             r_cnt <= i_load_val;
    else if (i_dec && !o_expired) r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/fpll_rcnf_engine.sv
// Read-modify-write reconfiguration engine between the fPLL recalibration
// sequencer and the TX PLL Avalon-MM reconfiguration port.
//   rcnf_*          : single-cycle command strobes + reconfig addr/data/mask
//   rcnf_busy       : combinational, so a strobe reads busy in its own cycle
//   cal_busy        : TX PLL calibration busy (already in clk domain)
//   txpll_mgmt_*    : Avalon-MM master (read/write held through waitrequest)
//   cal_result(_valid): word captured by scalib, valid pulses once
//   err_cmd/err_timeout: sticky until reset
module fpll_rcnf_engine
  import fpll_rcnf_pkg::*;
#(
  parameter int         CAL_START_CYC   = 1024,
  parameter int         CAL_TIMEOUT_CYC = 1 << 20,
  parameter int         POLL_MAX        = 255,
  parameter logic [9:0] CAL_STORE_ADDR  = 10'h100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rcnf_reconfig,
  input  logic        rcnf_req_cbus,
  input  logic        rcnf_rel_cbus,
  input  logic        rcnf_wcalib,
  input  logic        rcnf_scalib,
  input  logic [9:0]  rcnf_address,
  input  logic [31:0] rcnf_data,
  input  logic [31:0] rcnf_mask,
  output logic        rcnf_busy,
  input  logic        cal_busy,
  output logic [9:0]  txpll_mgmt_address,
  output logic [31:0] txpll_mgmt_writedata,
  input  logic [31:0] txpll_mgmt_readdata,
  output logic        txpll_mgmt_write,
  output logic        txpll_mgmt_read,
  input  logic        txpll_mgmt_waitrequest,
  output logic [31:0] cal_result,
  output logic        cal_result_valid,
  output logic        err_cmd,
  output logic        err_timeout
);

  state_t            r_state, w_state_nxt;
  op_t               r_op;
  logic [9:0]        r_addr;
  logic [31:0]       r_data, r_mask, r_wdata;
  logic              r_gap, w_gap_nxt;
  logic [4:0]        w_strb;
  logic              w_any, w_multi;
  logic              w_tmr_load, w_tmr_dec, w_tmr_exp, w_set_to;
  logic [TMR_W-1:0]  w_tmr_val;

  assign w_strb  = {rcnf_reconfig, rcnf_req_cbus, rcnf_rel_cbus, rcnf_wcalib, rcnf_scalib};
  assign w_any   = |w_strb;
  assign w_multi = (w_strb & (w_strb - 5'd1)) != 5'd0;  // more than one bit set

  assign rcnf_busy            = (r_state != S_IDLE) || w_any;
  assign txpll_mgmt_write     = (r_state == S_WR);
  // r_gap drops read for one cycle between successive poll reads.
  assign txpll_mgmt_read      = (r_state == S_RD) || ((r_state == S_POLL_RD) && !r_gap);
  assign txpll_mgmt_address   = (r_state == S_POLL_RD) ? ADDR_CAPAB_STATUS : r_addr;
  assign txpll_mgmt_writedata = r_wdata;

  fpll_rcnf_timer #(.W(TMR_W)) u_tmr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_expired  (w_tmr_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    w_set_to    = 1'b0;
    w_gap_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rcnf_reconfig)      w_state_nxt = S_RD;
        else if (rcnf_req_cbus) w_state_nxt = S_WR;
        else if (rcnf_rel_cbus) w_state_nxt = S_WR;
        else if (rcnf_wcalib) begin
          w_state_nxt = S_CAL_RISE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(CAL_START_CYC);
        end
        else if (rcnf_scalib)   w_state_nxt = S_RD;
      end
      S_RD:
        if (!txpll_mgmt_waitrequest)
          w_state_nxt = (r_op == OP_SCAL) ? S_IDLE : S_WR;
      S_WR:
        if (!txpll_mgmt_waitrequest) begin
          if (r_op == OP_REQ) begin
            w_state_nxt = S_POLL_RD;
            w_tmr_load  = 1'b1;
            // One step per busy read: the POLL_MAX-th busy read gives up.
            w_tmr_val   = TMR_W'(POLL_MAX - 1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      S_POLL_RD:
        if (!r_gap && !txpll_mgmt_waitrequest) begin
          if (!txpll_mgmt_readdata[CBUS_BUSY_BIT]) w_state_nxt = S_IDLE;
          else if (w_tmr_exp) begin
            w_set_to    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmr_dec = 1'b1;
            w_gap_nxt = 1'b1;
          end
        end
      S_CAL_RISE:
        if (cal_busy) begin
          w_state_nxt = S_CAL_FALL;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(CAL_TIMEOUT_CYC);
        end
        // No rise seen: calibration already finished, not an error.
        else if (w_tmr_exp) w_state_nxt = S_IDLE;
        else                w_tmr_dec   = 1'b1;
      S_CAL_FALL:
        if (!cal_busy) w_state_nxt = S_IDLE;
        else if (w_tmr_exp) begin
          w_set_to    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        else w_tmr_dec = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op             <= OP_RCNF;
      r_addr           <= '0;
      r_data           <= '0;
      r_mask           <= '0;
      r_wdata          <= '0;
      r_gap            <= 1'b0;
      cal_result       <= '0;
      cal_result_valid <= 1'b0;
      err_cmd          <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      r_gap            <= w_gap_nxt;
      cal_result_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_multi) err_cmd <= 1'b1;
        if (rcnf_reconfig) begin
          r_op   <= OP_RCNF;
          r_addr <= rcnf_address;
          r_data <= rcnf_data;
          r_mask <= rcnf_mask;
        end else if (rcnf_req_cbus) begin
          r_op    <= OP_REQ;
          r_addr  <= ADDR_CBUS_ARB;
          r_wdata <= CBUS_REQ;
        end else if (rcnf_rel_cbus) begin
          r_op    <= OP_REL;
          r_addr  <= ADDR_CBUS_ARB;
          r_wdata <= CBUS_REL;
        end else if (!rcnf_wcalib && rcnf_scalib) begin
          r_op   <= OP_SCAL;
          r_addr <= CAL_STORE_ADDR;
        end
      end else if (w_any) begin
        err_cmd <= 1'b1;
      end
      if ((r_state == S_RD) && !txpll_mgmt_waitrequest) begin
        if (r_op == OP_SCAL) begin
          cal_result       <= txpll_mgmt_readdata;
          cal_result_valid <= 1'b1;
        end else begin
          r_wdata <= rmw_merge(txpll_mgmt_readdata, r_data, r_mask);
        end
      end
      if (w_set_to) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpll_rcnf_engine.sv
// Directed bench for fpll_rcnf_engine. Inputs change on the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_fpll_rcnf_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rcnf_reconfig, rcnf_req_cbus, rcnf_rel_cbus, rcnf_wcalib, rcnf_scalib;
  logic [9:0]  rcnf_address;
  logic [31:0] rcnf_data, rcnf_mask;
  logic        rcnf_busy, cal_busy;
  logic [9:0]  txpll_mgmt_address;
  logic [31:0] txpll_mgmt_writedata, txpll_mgmt_readdata;
  logic        txpll_mgmt_write, txpll_mgmt_read, txpll_mgmt_waitrequest;
  logic [31:0] cal_result;
  logic        cal_result_valid, err_cmd, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  fpll_rcnf_engine #(
    .CAL_START_CYC(20), .CAL_TIMEOUT_CYC(1000), .POLL_MAX(5), .CAL_STORE_ADDR(10'h100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rcnf_reconfig(rcnf_reconfig), .rcnf_req_cbus(rcnf_req_cbus),
    .rcnf_rel_cbus(rcnf_rel_cbus), .rcnf_wcalib(rcnf_wcalib), .rcnf_scalib(rcnf_scalib),
    .rcnf_address(rcnf_address), .rcnf_data(rcnf_data), .rcnf_mask(rcnf_mask),
    .rcnf_busy(rcnf_busy), .cal_busy(cal_busy),
    .txpll_mgmt_address(txpll_mgmt_address), .txpll_mgmt_writedata(txpll_mgmt_writedata),
    .txpll_mgmt_readdata(txpll_mgmt_readdata), .txpll_mgmt_write(txpll_mgmt_write),
    .txpll_mgmt_read(txpll_mgmt_read), .txpll_mgmt_waitrequest(txpll_mgmt_waitrequest),
    .cal_result(cal_result), .cal_result_valid(cal_result_valid),
    .err_cmd(err_cmd), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Next falling edge; strobes default low.
  task automatic tick();
    @(negedge clk);
    {rcnf_reconfig, rcnf_req_cbus, rcnf_rel_cbus, rcnf_wcalib, rcnf_scalib} = '0;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic strobe_rcnf();
    rcnf_reconfig = 1'b1;
    rcnf_address  = 10'h12b;
    rcnf_data     = 32'h5a;
    rcnf_mask     = 32'hff;
  endtask

  // Plain reconfig with no waitrequest; tag prefixes the check names.
  task automatic rcnf_basic(input string t);
    tick(); strobe_rcnf(); txpll_mgmt_waitrequest = 1'b0;
    txpll_mgmt_readdata = 32'h1234_5600; #1;
    chk({t, "_busy_c0"}, 32'(rcnf_busy), 32'd1);
    chk({t, "_rd_c0"}, 32'(txpll_mgmt_read), 32'd0);
    tick(); #1;
    chk({t, "_rd_c1"}, 32'(txpll_mgmt_read), 32'd1);
    chk({t, "_addr_c1"}, 32'(txpll_mgmt_address), 32'h12b);
    chk({t, "_wr_c1"}, 32'(txpll_mgmt_write), 32'd0);
    tick(); txpll_mgmt_readdata = 32'hdead_beef; #1;
    chk({t, "_wr_c2"}, 32'(txpll_mgmt_write), 32'd1);
    chk({t, "_rd_c2"}, 32'(txpll_mgmt_read), 32'd0);
    chk({t, "_wdata_c2"}, txpll_mgmt_writedata, 32'h1234_565a);
    tick(); #1;
    chk({t, "_busy_c3"}, 32'(rcnf_busy), 32'd0);
    chk({t, "_wr_c3"}, 32'(txpll_mgmt_write), 32'd0);
  endtask

  // req_cbus; poll readdata shows busy for the first nbusy reads.
  task automatic run_poll(input int nbusy, output int nrd);
    nrd = 0;
    tick(); rcnf_req_cbus = 1'b1; txpll_mgmt_waitrequest = 1'b0; #1;
    chk("poll_busy_c0", 32'(rcnf_busy), 32'd1);
    tick(); #1;
    chk("poll_wr_c1", 32'(txpll_mgmt_write), 32'd1);
    chk("poll_waddr_c1", 32'(txpll_mgmt_address), 32'h000);
    chk("poll_wdata_c1", txpll_mgmt_writedata, 32'h2);
    for (int i = 0; i < 100; i++) begin
      tick();
      txpll_mgmt_readdata = (nrd < nbusy) ? 32'hffff_ffff : 32'hffff_fffb;
      #1;
      if (!rcnf_busy) return;
      if (txpll_mgmt_read) begin
        if (txpll_mgmt_address !== 10'h280) chk("poll_raddr", 32'(txpll_mgmt_address), 32'h280);
        nrd++;
      end
    end
    chk("poll_bound", 32'd1, 32'd0);
  endtask

  // wcalib; cal_busy is high for cycles [rise, fall) counted from the strobe.
  task automatic run_cal(input int rise, input int fall, output int n);
    n = 0;
    tick(); rcnf_wcalib = 1'b1; cal_busy = (rise == 0) && (fall > 0); #1;
    if (rcnf_busy) n++;
    for (int c = 1; c < 4000; c++) begin
      tick(); cal_busy = (c >= rise) && (c < fall); #1;
      if (!rcnf_busy) break;
      n++;
    end
    cal_busy = 1'b0;
  endtask

  int nrd, nb;

  initial begin
    reset_n = 1'b0;
    {rcnf_reconfig, rcnf_req_cbus, rcnf_rel_cbus, rcnf_wcalib, rcnf_scalib} = '0;
    rcnf_address = '0; rcnf_data = '0; rcnf_mask = '0; cal_busy = 1'b0;
    txpll_mgmt_readdata = '0; txpll_mgmt_waitrequest = 1'b0;
    #6;
    chk("rst_busy", 32'(rcnf_busy), 32'd0);
    chk("rst_rdwr", {30'd0, txpll_mgmt_read, txpll_mgmt_write}, 32'd0);
    chk("rst_addr", 32'(txpll_mgmt_address), 32'd0);
    chk("rst_wdata", txpll_mgmt_writedata, 32'd0);
    chk("rst_calres", cal_result, 32'd0);
    chk("rst_flags", {29'd0, cal_result_valid, err_cmd, err_timeout}, 32'd0);
    tick(); reset_n = 1'b1;

    rcnf_basic("rmw");

    // Read stalled by waitrequest for 4 cycles; readdata only valid on completion.
    tick(); strobe_rcnf(); txpll_mgmt_waitrequest = 1'b1; txpll_mgmt_readdata = 32'hdead_beef; #1;
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      chk("ws_rd_held", 32'(txpll_mgmt_read), 32'd1);
      chk("ws_addr_held", 32'(txpll_mgmt_address), 32'h12b);
      chk("ws_no_wr", 32'(txpll_mgmt_write), 32'd0);
    end
    tick(); txpll_mgmt_waitrequest = 1'b0; txpll_mgmt_readdata = 32'h1234_5600; #1;
    chk("ws_rd_c5", 32'(txpll_mgmt_read), 32'd1);
    tick(); txpll_mgmt_readdata = 32'hdead_beef; #1;
    chk("ws_wr_c6", 32'(txpll_mgmt_write), 32'd1);
    chk("ws_wdata_c6", txpll_mgmt_writedata, 32'h1234_565a);
    tick(); #1;
    chk("ws_idle_c7", 32'(rcnf_busy), 32'd0);

    run_poll(3, nrd);
    chk("poll_nreads", 32'(nrd), 32'd4);
    chk("poll_no_to", 32'(err_timeout), 32'd0);

    tick(); rcnf_rel_cbus = 1'b1; #1;
    tick(); #1;
    chk("rel_wr", 32'(txpll_mgmt_write), 32'd1);
    chk("rel_addr", 32'(txpll_mgmt_address), 32'h000);
    chk("rel_wdata", txpll_mgmt_writedata, 32'h1);
    tick(); #1;
    chk("rel_idle", 32'(rcnf_busy), 32'd0);

    tick(); rcnf_scalib = 1'b1; #1;
    tick(); txpll_mgmt_readdata = 32'hcafe_f00d; #1;
    chk("scal_rd", 32'(txpll_mgmt_read), 32'd1);
    chk("scal_addr", 32'(txpll_mgmt_address), 32'h100);
    chk("scal_vld_early", 32'(cal_result_valid), 32'd0);
    tick(); #1;
    chk("scal_vld", 32'(cal_result_valid), 32'd1);
    chk("scal_res", cal_result, 32'hcafe_f00d);
    chk("scal_no_wr", 32'(txpll_mgmt_write), 32'd0);
    chk("scal_idle", 32'(rcnf_busy), 32'd0);
    tick(); #1;
    chk("scal_vld_pulse", 32'(cal_result_valid), 32'd0);

    run_cal(10, 510, nb);
    chk("cal_busy_len", 32'(nb), 32'd511);
    chk("cal_no_to", 32'(err_timeout), 32'd0);
    run_cal(100000, 100000, nb);
    chk("cal_norise_len", 32'(nb), 32'd22);
    chk("cal_norise_no_to", 32'(err_timeout), 32'd0);
    chk("no_err_cmd_yet", 32'(err_cmd), 32'd0);

    // reconfig and scalib together: reconfig wins.
    tick(); strobe_rcnf(); rcnf_scalib = 1'b1; txpll_mgmt_readdata = 32'h1234_5600; #1;
    tick(); #1;
    chk("multi_addr", 32'(txpll_mgmt_address), 32'h12b);
    tick(); #1;
    chk("multi_wdata", txpll_mgmt_writedata, 32'h1234_565a);
    tick(); #1;
    chk("multi_idle", 32'(rcnf_busy), 32'd0);
    chk("multi_err_cmd", 32'(err_cmd), 32'd1);
    chk("multi_no_calvld", 32'(cal_result_valid), 32'd0);

    do_reset(); #1;
    chk("rst2_err_cmd", 32'(err_cmd), 32'd0);
    // rel_cbus strobed during WR is dropped.
    tick(); strobe_rcnf(); #1;
    tick(); #1;
    tick(); rcnf_rel_cbus = 1'b1; #1;
    chk("inwr_wr", 32'(txpll_mgmt_write), 32'd1);
    tick(); #1;
    chk("inwr_idle", 32'(rcnf_busy), 32'd0);
    chk("inwr_no_wr", 32'(txpll_mgmt_write), 32'd0);
    chk("inwr_err_cmd", 32'(err_cmd), 32'd1);

    do_reset();
    run_poll(100, nrd);
    chk("pollto_nreads", 32'(nrd), 32'd5);
    chk("pollto_err", 32'(err_timeout), 32'd1);

    do_reset(); #1;
    chk("rst3_err_to", 32'(err_timeout), 32'd0);
    run_cal(0, 100000, nb);
    chk("calto_len", 32'(nb), 32'd1003);
    chk("calto_err", 32'(err_timeout), 32'd1);

    // Async reset in the middle of a write.
    do_reset();
    tick(); strobe_rcnf(); txpll_mgmt_readdata = 32'h1234_5600; #1;
    tick(); #1;
    tick(); #1;
    chk("arst_pre_wr", 32'(txpll_mgmt_write), 32'd1);
    reset_n = 1'b0; #1;
    chk("arst_wr", 32'(txpll_mgmt_write), 32'd0);
    chk("arst_busy", 32'(rcnf_busy), 32'd0);
    chk("arst_addr", 32'(txpll_mgmt_address), 32'd0);
    chk("arst_wdata", txpll_mgmt_writedata, 32'd0);
    chk("arst_flags", {29'd0, txpll_mgmt_read, err_cmd, err_timeout}, 32'd0);
    tick(); tick(); reset_n = 1'b1;
    rcnf_basic("post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
